// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl
// Description : Multi-cycle MIPS control unit. A Moore FSM sequences fetch,
//               decode, execute, memory and writeback, and drives the datapath
//               mux selects, write enables and the 5-bit ALU operation code.
//               The only combinational input-to-output path from Zero is
//               PCWrite while in BRANCH.
// Ports       : clk, rstn (async active-low)
//               Op/Funct/Rt       - fields of the (already latched) IR
//               Zero              - ALU result-is-zero flag
//               PCWrite, IorD, MemWrite, IRWrite, RegWrite  - strobes/selects
//               RegDst, WDSel, ALUSrcA, ALUSrcB, EXTOp, ALUOp, PCSource
//               illegal           - one-cycle pulse on an undecodable instr
//               state             - current FSM state (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module mc_ctrl #(
    parameter int RA_IDX = 31
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic [4:0] Rt,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] WDSel,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       EXTOp,
    output logic [4:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       illegal,
    output logic [3:0] state
);

    // ALU operation encoding shared with the ALU
    localparam logic [4:0] c_ALU_NOP  = 5'd0;
    localparam logic [4:0] c_ALU_ADD  = 5'd1;
    localparam logic [4:0] c_ALU_SUB  = 5'd2;
    localparam logic [4:0] c_ALU_AND  = 5'd3;
    localparam logic [4:0] c_ALU_OR   = 5'd4;
    localparam logic [4:0] c_ALU_XOR  = 5'd5;
    localparam logic [4:0] c_ALU_NOR  = 5'd6;
    localparam logic [4:0] c_ALU_SLT  = 5'd7;
    localparam logic [4:0] c_ALU_SLTU = 5'd8;
    localparam logic [4:0] c_ALU_SLL  = 5'd9;
    localparam logic [4:0] c_ALU_SRL  = 5'd10;
    localparam logic [4:0] c_ALU_SRA  = 5'd11;
    localparam logic [4:0] c_ALU_LUI  = 5'd12;
    localparam logic [4:0] c_ALU_BLEZ = 5'd13;
    localparam logic [4:0] c_ALU_BGTZ = 5'd14;
    localparam logic [4:0] c_ALU_BLTZ = 5'd15;
    localparam logic [4:0] c_ALU_BGEZ = 5'd16;

    // Opcodes
    localparam logic [5:0] c_OP_RTYPE  = 6'b000000;
    localparam logic [5:0] c_OP_REGIMM = 6'b000001;
    localparam logic [5:0] c_OP_J      = 6'b000010;
    localparam logic [5:0] c_OP_JAL    = 6'b000011;
    localparam logic [5:0] c_OP_BEQ    = 6'b000100;
    localparam logic [5:0] c_OP_BNE    = 6'b000101;
    localparam logic [5:0] c_OP_BLEZ   = 6'b000110;
    localparam logic [5:0] c_OP_BGTZ   = 6'b000111;
    localparam logic [5:0] c_OP_ADDI   = 6'b001000;
    localparam logic [5:0] c_OP_SLTI   = 6'b001010;
    localparam logic [5:0] c_OP_SLTIU  = 6'b001011;
    localparam logic [5:0] c_OP_ANDI   = 6'b001100;
    localparam logic [5:0] c_OP_ORI    = 6'b001101;
    localparam logic [5:0] c_OP_XORI   = 6'b001110;
    localparam logic [5:0] c_OP_LUI    = 6'b001111;
    localparam logic [5:0] c_OP_LW     = 6'b100011;
    localparam logic [5:0] c_OP_SW     = 6'b101011;

    // R-type function codes
    localparam logic [5:0] c_FN_SLL  = 6'b000000;
    localparam logic [5:0] c_FN_SRL  = 6'b000010;
    localparam logic [5:0] c_FN_SRA  = 6'b000011;
    localparam logic [5:0] c_FN_SLLV = 6'b000100;
    localparam logic [5:0] c_FN_SRLV = 6'b000110;
    localparam logic [5:0] c_FN_SRAV = 6'b000111;
    localparam logic [5:0] c_FN_JR   = 6'b001000;
    localparam logic [5:0] c_FN_ADD  = 6'b100000;
    localparam logic [5:0] c_FN_ADDU = 6'b100001;
    localparam logic [5:0] c_FN_SUB  = 6'b100010;
    localparam logic [5:0] c_FN_SUBU = 6'b100011;
    localparam logic [5:0] c_FN_AND  = 6'b100100;
    localparam logic [5:0] c_FN_OR   = 6'b100101;
    localparam logic [5:0] c_FN_XOR  = 6'b100110;
    localparam logic [5:0] c_FN_NOR  = 6'b100111;
    localparam logic [5:0] c_FN_SLT  = 6'b101010;
    localparam logic [5:0] c_FN_SLTU = 6'b101011;

    // The datapath applies RA_IDX when RegDst=10; the controller only
    // carries it so both sides are configured from one place.
    localparam logic [4:0] c_RA_IDX = 5'(RA_IDX);
    logic w_unused_ra;
    assign w_unused_ra = ^c_RA_IDX;

    typedef enum logic [3:0] {
        ST_RESET  = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_MEMADR = 4'd3,
        ST_MEMRD  = 4'd4,
        ST_MEMWB  = 4'd5,
        ST_MEMWR  = 4'd6,
        ST_EXE_R  = 4'd7,
        ST_EXE_I  = 4'd8,
        ST_ALUWB  = 4'd9,
        ST_BRANCH = 4'd10,
        ST_JUMP   = 4'd11,
        ST_JR     = 4'd12
    } state_t;

    state_t r_state;
    state_t w_next;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_next;
        end
    end

    assign state = r_state;

    always_comb begin
        w_next   = ST_FETCH;
        PCWrite  = 1'b0;
        IorD     = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegWrite = 1'b0;
        RegDst   = 2'b00;
        WDSel    = 2'b00;
        ALUSrcA  = 2'b00;
        ALUSrcB  = 2'b00;
        EXTOp    = 1'b0;
        ALUOp    = c_ALU_NOP;
        PCSource = 2'b00;
        illegal  = 1'b0;

        case (r_state)
            ST_RESET: begin
                w_next = ST_FETCH;
            end

            ST_FETCH: begin
                IRWrite = 1'b1;
                ALUSrcB = 2'b01;
                ALUOp   = c_ALU_ADD;
                PCWrite = 1'b1;
                w_next  = ST_DECODE;
            end

            // ALUOut <= PC+4 + (sext(imm)<<2): branch target ready for BRANCH
            ST_DECODE: begin
                ALUSrcB = 2'b11;
                EXTOp   = 1'b1;
                ALUOp   = c_ALU_ADD;
                case (Op)
                    c_OP_LW, c_OP_SW: w_next = ST_MEMADR;
                    c_OP_RTYPE:       w_next = (Funct == c_FN_JR) ? ST_JR : ST_EXE_R;
                    c_OP_ADDI, c_OP_ANDI, c_OP_ORI, c_OP_XORI,
                    c_OP_SLTI, c_OP_SLTIU, c_OP_LUI:
                                      w_next = ST_EXE_I;
                    c_OP_BEQ, c_OP_BNE, c_OP_BLEZ, c_OP_BGTZ:
                                      w_next = ST_BRANCH;
                    c_OP_REGIMM: begin
                        // Only rt=0 (bltz) and rt=1 (bgez) are implemented
                        if (Rt == 5'd0 || Rt == 5'd1) begin
                            w_next = ST_BRANCH;
                        end else begin
                            illegal = 1'b1;
                            w_next  = ST_FETCH;
                        end
                    end
                    c_OP_J, c_OP_JAL: w_next = ST_JUMP;
                    default: begin
                        illegal = 1'b1;
                        w_next  = ST_FETCH;
                    end
                endcase
            end

            ST_MEMADR: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                EXTOp   = 1'b1;
                ALUOp   = c_ALU_ADD;
                w_next  = (Op == c_OP_SW) ? ST_MEMWR : ST_MEMRD;
            end

            ST_MEMRD: begin
                IorD   = 1'b1;
                w_next = ST_MEMWB;
            end

            ST_MEMWB: begin
                RegWrite = 1'b1;
                WDSel    = 2'b01;
                w_next   = ST_FETCH;
            end

            ST_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                w_next   = ST_FETCH;
            end

            ST_EXE_R: begin
                ALUSrcA = 2'b01;
                w_next  = ST_ALUWB;
                case (Funct)
                    c_FN_ADD, c_FN_ADDU: ALUOp = c_ALU_ADD;
                    c_FN_SUB, c_FN_SUBU: ALUOp = c_ALU_SUB;
                    c_FN_AND:  ALUOp = c_ALU_AND;
                    c_FN_OR:   ALUOp = c_ALU_OR;
                    c_FN_XOR:  ALUOp = c_ALU_XOR;
                    c_FN_NOR:  ALUOp = c_ALU_NOR;
                    c_FN_SLT:  ALUOp = c_ALU_SLT;
                    c_FN_SLTU: ALUOp = c_ALU_SLTU;
                    c_FN_SLLV: ALUOp = c_ALU_SLL;
                    c_FN_SRLV: ALUOp = c_ALU_SRL;
                    c_FN_SRAV: ALUOp = c_ALU_SRA;
                    // Constant shifts take the amount from IR[10:6] via the shamt path
                    c_FN_SLL: begin ALUSrcA = 2'b10; ALUOp = c_ALU_SLL; end
                    c_FN_SRL: begin ALUSrcA = 2'b10; ALUOp = c_ALU_SRL; end
                    c_FN_SRA: begin ALUSrcA = 2'b10; ALUOp = c_ALU_SRA; end
                    default: begin
                        ALUSrcA = 2'b00;
                        illegal = 1'b1;
                        w_next  = ST_FETCH;
                    end
                endcase
            end

            ST_EXE_I: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                w_next  = ST_ALUWB;
                case (Op)
                    c_OP_ADDI:  begin EXTOp = 1'b1; ALUOp = c_ALU_ADD;  end
                    c_OP_SLTI:  begin EXTOp = 1'b1; ALUOp = c_ALU_SLT;  end
                    c_OP_SLTIU: begin EXTOp = 1'b1; ALUOp = c_ALU_SLTU; end
                    c_OP_ANDI:  ALUOp = c_ALU_AND;
                    c_OP_ORI:   ALUOp = c_ALU_OR;
                    c_OP_XORI:  ALUOp = c_ALU_XOR;
                    c_OP_LUI:   ALUOp = c_ALU_LUI;
                    default:    ALUOp = c_ALU_NOP;
                endcase
            end

            ST_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = (Op == c_OP_RTYPE) ? 2'b01 : 2'b00;
                w_next   = ST_FETCH;
            end

            // The ALU yields zero when the tested condition holds, so every
            // branch except bne takes the PC load straight from Zero.
            ST_BRANCH: begin
                ALUSrcA  = 2'b01;
                PCSource = 2'b01;
                w_next   = ST_FETCH;
                case (Op)
                    c_OP_BEQ:  begin ALUOp = c_ALU_SUB;  PCWrite = Zero;  end
                    c_OP_BNE:  begin ALUOp = c_ALU_SUB;  PCWrite = !Zero; end
                    c_OP_BLEZ: begin ALUOp = c_ALU_BLEZ; PCWrite = Zero;  end
                    c_OP_BGTZ: begin ALUOp = c_ALU_BGTZ; PCWrite = Zero;  end
                    c_OP_REGIMM: begin
                        ALUOp   = Rt[0] ? c_ALU_BGEZ : c_ALU_BLTZ;
                        PCWrite = Zero;
                    end
                    default: PCWrite = 1'b0;
                endcase
            end

            // PC already holds PC+4 here, which is the jal link value
            ST_JUMP: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
                if (Op == c_OP_JAL) begin
                    RegWrite = 1'b1;
                    RegDst   = 2'b10;
                    WDSel    = 2'b10;
                end
                w_next = ST_FETCH;
            end

            ST_JR: begin
                PCSource = 2'b11;
                PCWrite  = 1'b1;
                w_next   = ST_FETCH;
            end

            default: begin
                w_next = ST_FETCH;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_ctrl
// Description : Self-checking bench for mc_ctrl. A per-cycle table of inputs
//               and expected output words is applied in a loop; expectations
//               go through a scoreboard queue and are compared mid-cycle.
//               Reset and an async abort during MEMWR are hand-sequenced.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl;

    // ALU codes and state codes as seen on the debug port
    localparam logic [4:0] A_NOP = 5'd0,  A_ADD = 5'd1,  A_SUB = 5'd2,  A_AND = 5'd3;
    localparam logic [4:0] A_OR  = 5'd4,  A_XOR = 5'd5,  A_NOR = 5'd6,  A_SLT = 5'd7;
    localparam logic [4:0] A_SLTU = 5'd8, A_SLL = 5'd9,  A_SRL = 5'd10, A_SRA = 5'd11;
    localparam logic [4:0] A_LUI = 5'd12, A_BLEZ = 5'd13, A_BGTZ = 5'd14;
    localparam logic [4:0] A_BLTZ = 5'd15, A_BGEZ = 5'd16;

    localparam logic [3:0] S_RESET = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD = 4'd4, S_MEMWB = 4'd5, S_MEMWR = 4'd6, S_EXE_R = 4'd7;
    localparam logic [3:0] S_EXE_I = 4'd8, S_ALUWB = 4'd9, S_BRANCH = 4'd10, S_JUMP = 4'd11;
    localparam logic [3:0] S_JR = 4'd12;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [5:0] Op = 6'd0;
    logic [5:0] Funct = 6'd0;
    logic [4:0] Rt = 5'd0;
    logic       Zero = 1'b0;
    logic       PCWrite, IorD, MemWrite, IRWrite, RegWrite, EXTOp, illegal;
    logic [1:0] RegDst, WDSel, ALUSrcA, ALUSrcB, PCSource;
    logic [4:0] ALUOp;
    logic [3:0] state;

    int checks = 0;
    int failures = 0;

    mc_ctrl #(.RA_IDX(31)) dut (
        .clk(clk), .rstn(rstn), .Op(Op), .Funct(Funct), .Rt(Rt), .Zero(Zero),
        .PCWrite(PCWrite), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .RegDst(RegDst), .WDSel(WDSel), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .EXTOp(EXTOp), .ALUOp(ALUOp), .PCSource(PCSource),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    // {PCWrite,IorD,MemWrite,IRWrite,RegWrite,RegDst,WDSel,ALUSrcA,ALUSrcB,
    //  EXTOp,ALUOp,PCSource,illegal,state}
    logic [25:0] w_act;
    assign w_act = {PCWrite, IorD, MemWrite, IRWrite, RegWrite, RegDst, WDSel,
                    ALUSrcA, ALUSrcB, EXTOp, ALUOp, PCSource, illegal, state};

    function automatic logic [25:0] ew(
        input logic pcw, input logic iord, input logic memw, input logic irw,
        input logic regw, input logic [1:0] regdst, input logic [1:0] wdsel,
        input logic [1:0] srca, input logic [1:0] srcb, input logic ext,
        input logic [4:0] aluop, input logic [1:0] pcsrc, input logic ill,
        input logic [3:0] st);
        return {pcw, iord, memw, irw, regw, regdst, wdsel, srca, srcb, ext,
                aluop, pcsrc, ill, st};
    endfunction

    function automatic logic [25:0] e_fetch();
        return ew(1,0,0,1,0, 2'd0,2'd0,2'd0,2'd1, 0, A_ADD, 2'd0, 0, S_FETCH);
    endfunction
    function automatic logic [25:0] e_decode(input logic ill);
        return ew(0,0,0,0,0, 2'd0,2'd0,2'd0,2'd3, 1, A_ADD, 2'd0, ill, S_DECODE);
    endfunction
    function automatic logic [25:0] e_memadr();
        return ew(0,0,0,0,0, 2'd0,2'd0,2'd1,2'd2, 1, A_ADD, 2'd0, 0, S_MEMADR);
    endfunction
    function automatic logic [25:0] e_memrd();
        return ew(0,1,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0, A_NOP, 2'd0, 0, S_MEMRD);
    endfunction
    function automatic logic [25:0] e_memwb();
        return ew(0,0,0,0,1, 2'd0,2'd1,2'd0,2'd0, 0, A_NOP, 2'd0, 0, S_MEMWB);
    endfunction
    function automatic logic [25:0] e_memwr();
        return ew(0,1,1,0,0, 2'd0,2'd0,2'd0,2'd0, 0, A_NOP, 2'd0, 0, S_MEMWR);
    endfunction
    function automatic logic [25:0] e_exer(input logic [1:0] srca, input logic [4:0] op,
                                           input logic ill);
        return ew(0,0,0,0,0, 2'd0,2'd0,srca,2'd0, 0, op, 2'd0, ill, S_EXE_R);
    endfunction
    function automatic logic [25:0] e_exei(input logic ext, input logic [4:0] op);
        return ew(0,0,0,0,0, 2'd0,2'd0,2'd1,2'd2, ext, op, 2'd0, 0, S_EXE_I);
    endfunction
    function automatic logic [25:0] e_aluwb(input logic [1:0] regdst);
        return ew(0,0,0,0,1, regdst,2'd0,2'd0,2'd0, 0, A_NOP, 2'd0, 0, S_ALUWB);
    endfunction
    function automatic logic [25:0] e_branch(input logic pcw, input logic [4:0] op);
        return ew(pcw,0,0,0,0, 2'd0,2'd0,2'd1,2'd0, 0, op, 2'd1, 0, S_BRANCH);
    endfunction
    function automatic logic [25:0] e_jump(input logic jal);
        return ew(1,0,0,0,jal, jal ? 2'd2 : 2'd0, jal ? 2'd2 : 2'd0, 2'd0,2'd0,
                  0, A_NOP, 2'd2, 0, S_JUMP);
    endfunction
    function automatic logic [25:0] e_jr();
        return ew(1,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0, A_NOP, 2'd3, 0, S_JR);
    endfunction

    typedef struct {
        string       tag;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic [4:0]  rt;
        logic        zero;
        logic [25:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [25:0] sb_exp[$];
    string       sb_tag[$];

    // Current instruction fields used by add()
    string      cur_tag;
    logic [5:0] cur_op, cur_fn;
    logic [4:0] cur_rt;
    logic       cur_z;

    task automatic add(input logic [25:0] exp);
        vec_t v;
        v.tag = cur_tag; v.op = cur_op; v.funct = cur_fn; v.rt = cur_rt;
        v.zero = cur_z; v.exp = exp;
        vecs.push_back(v);
    endtask

    // Starts an instruction: its FETCH cycle, plus a legal DECODE cycle
    task automatic instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] rt, input logic z, input logic dec);
        cur_tag = tag; cur_op = op; cur_fn = fn; cur_rt = rt; cur_z = z;
        add(e_fetch());
        if (dec) add(e_decode(1'b0));
    endtask

    task automatic check(input string tag, input logic [25:0] exp);
        checks++;
        if (w_act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (state got=%0d exp=%0d)",
                     tag, w_act, exp, state, exp[3:0]);
        end
    endtask

    initial begin
        // ---------------- vector table ----------------
        instr("lw",    6'b100011, 6'd0, 5'd0, 0, 1);
        add(e_memadr()); add(e_memrd()); add(e_memwb());
        instr("sw",    6'b101011, 6'd0, 5'd0, 0, 1);
        add(e_memadr()); add(e_memwr());
        instr("sra",   6'd0, 6'b000011, 5'd0, 0, 1); add(e_exer(2'd2, A_SRA, 0));  add(e_aluwb(2'd1));
        instr("add",   6'd0, 6'b100000, 5'd0, 0, 1); add(e_exer(2'd1, A_ADD, 0));  add(e_aluwb(2'd1));
        instr("subu",  6'd0, 6'b100011, 5'd0, 0, 1); add(e_exer(2'd1, A_SUB, 0));  add(e_aluwb(2'd1));
        instr("nor",   6'd0, 6'b100111, 5'd0, 0, 1); add(e_exer(2'd1, A_NOR, 0));  add(e_aluwb(2'd1));
        instr("sltu",  6'd0, 6'b101011, 5'd0, 0, 1); add(e_exer(2'd1, A_SLTU, 0)); add(e_aluwb(2'd1));
        instr("srlv",  6'd0, 6'b000110, 5'd0, 0, 1); add(e_exer(2'd1, A_SRL, 0));  add(e_aluwb(2'd1));
        instr("sll",   6'd0, 6'b000000, 5'd0, 0, 1); add(e_exer(2'd2, A_SLL, 0));  add(e_aluwb(2'd1));
        instr("ori",   6'b001101, 6'd0, 5'd0, 0, 1); add(e_exei(0, A_OR));   add(e_aluwb(2'd0));
        instr("addi",  6'b001000, 6'd0, 5'd0, 0, 1); add(e_exei(1, A_ADD));  add(e_aluwb(2'd0));
        instr("sltiu", 6'b001011, 6'd0, 5'd0, 0, 1); add(e_exei(1, A_SLTU)); add(e_aluwb(2'd0));
        instr("lui",   6'b001111, 6'd0, 5'd0, 0, 1); add(e_exei(0, A_LUI));  add(e_aluwb(2'd0));
        instr("beqZ1", 6'b000100, 6'd0, 5'd0, 1, 1); add(e_branch(1, A_SUB));
        instr("bneZ1", 6'b000101, 6'd0, 5'd0, 1, 1); add(e_branch(0, A_SUB));
        instr("bneZ0", 6'b000101, 6'd0, 5'd0, 0, 1); add(e_branch(1, A_SUB));
        instr("blez",  6'b000110, 6'd0, 5'd0, 0, 1); add(e_branch(0, A_BLEZ));
        instr("bgtz",  6'b000111, 6'd0, 5'd0, 1, 1); add(e_branch(1, A_BGTZ));
        instr("bltz",  6'b000001, 6'd0, 5'd0, 1, 1); add(e_branch(1, A_BLTZ));
        instr("bgez",  6'b000001, 6'd0, 5'd1, 0, 1); add(e_branch(0, A_BGEZ));
        instr("jal",   6'b000011, 6'd0, 5'd0, 0, 1); add(e_jump(1));
        instr("j",     6'b000010, 6'd0, 5'd0, 0, 1); add(e_jump(0));
        instr("jr",    6'd0, 6'b001000, 5'd0, 0, 1); add(e_jr());
        instr("badop", 6'b111111, 6'd0, 5'd0, 0, 0); add(e_decode(1'b1));
        instr("badfn", 6'd0, 6'b000001, 5'd0, 0, 1); add(e_exer(2'd0, A_NOP, 1));
        instr("badrt", 6'b000001, 6'd0, 5'd2, 0, 0); add(e_decode(1'b1));
        instr("swrst", 6'b101011, 6'd0, 5'd0, 0, 0);

        // ---------------- reset ----------------
        rstn = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("reset_hold%0d", i), 26'd0);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        check("reset_release", 26'd0);
        @(posedge clk); #1;

        // ---------------- table loop ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            Op = vecs[i].op; Funct = vecs[i].funct; Rt = vecs[i].rt; Zero = vecs[i].zero;
            sb_exp.push_back(vecs[i].exp);
            sb_tag.push_back($sformatf("%s_c%0d", vecs[i].tag, i));
            @(negedge clk);
            if (sb_exp.size() == 0) begin
                checks++; failures++;
                $display("FAIL scoreboard_empty got=0 entries exp=1");
            end else begin
                check(sb_tag.pop_front(), sb_exp.pop_front());
            end
            if (i + 1 < vecs.size()) begin
                @(posedge clk); #1;
            end
        end

        // ---------------- sw aborted by async reset in MEMWR ----------------
        // Op=sw already applied; the FETCH above leads into DECODE.
        @(posedge clk); #1;
        check("abort_decode", e_decode(1'b0));
        @(posedge clk); #1;
        check("abort_memadr", e_memadr());
        @(posedge clk); #1;
        check("abort_memwr", e_memwr());
        #1 rstn = 1'b0;
        #1 check("abort_async", 26'd0);
        @(negedge clk);
        check("abort_hold", 26'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        check("abort_release", 26'd0);
        @(posedge clk); #1;
        check("abort_refetch", e_fetch());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle MIPS control unit; the producer side of the ALU's ALUOp/Zero interface.
- Decodes the instruction register's Op/Funct/rt fields and sequences fetch, decode, execute, memory and writeback through a Moore FSM.
- Drives datapath muxes, write enables and the 5-bit ALUOp. Consumes ALU Zero for branch resolution.
- Sits beside the multi-cycle datapath (PC, IR, A/B/ALUOut/MDR registers, regfile, unified memory).

Parameters:
- RA_IDX, 31, register index written by jal.

Ports:
- clk  in  1  system clock, all state changes on rising edge
- rstn  in  1  asynchronous active-low reset
- Op  in  6  IR[31:26]
- Funct  in  6  IR[5:0]
- Rt  in  5  IR[20:16], selects bltz/bgez under Op=000001
- Zero  in  1  ALU Zero flag (C==0)
- PCWrite  out  1  PC load enable
- IorD  out  1  memory address select: 0=PC, 1=ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR load enable
- RegWrite  out  1  regfile write enable
- RegDst  out  2  write register select: 00=rt, 01=rd, 10=RA_IDX
- WDSel  out  2  write data select: 00=ALUOut, 01=MDR, 10=PC
- ALUSrcA  out  2  00=PC, 01=A reg, 10={21'b0,IR[10:0]} (shamt path)
- ALUSrcB  out  2  00=B reg, 01=32'd4, 10=ext(imm), 11=ext(imm)<<2
- EXTOp  out  1  1=sign-extend imm, 0=zero-extend
- ALUOp  out  5  op code from the shared ALU_* control-encoding defines
- PCSource  out  2  00=ALU C, 01=ALUOut, 10={PC[31:28],IR[25:0],2'b0}, 11=A reg (jr)
- illegal  out  1  one-cycle pulse on an undecodable instruction
- state  out  4  current FSM state, for debug

Behaviour:
- Outputs are a pure function of state plus the latched Op/Funct/Rt; no combinational path from Zero except PCWrite in BRANCH.
- Reset (rstn=0, async): state=RESET. All outputs 0, ALUOp=ALU_NOP. Reset mid-instruction aborts it with no further write strobes.
- RESET -> FETCH unconditionally.
- FETCH:
  - IorD=0, IRWrite=1, ALUSrcA=00, ALUSrcB=01, ALUOp=ADD, PCSource=00, PCWrite=1.
  - Next state DECODE.
- DECODE:
  - ALUSrcA=00, ALUSrcB=11, EXTOp=1, ALUOp=ADD, so ALUOut = branch target.
  - Next state by opcode:
    - lw/sw -> MEMADR
    - R-type (except jr) -> EXE_R
    - jr -> JR
    - addi/andi/ori/xori/slti/sltiu/lui -> EXE_I
    - beq/bne/blez/bgtz/bltz/bgez -> BRANCH
    - j/jal -> JUMP
    - else -> FETCH with illegal=1
- MEMADR:
  - ALUSrcA=01, ALUSrcB=10, EXTOp=1, ALUOp=ADD.
  - Next state MEMRD for lw, MEMWR for sw.
- MEMRD: IorD=1; next MEMWB.
- MEMWB: RegWrite=1, RegDst=00, WDSel=01; next FETCH.
- MEMWR: IorD=1, MemWrite=1; next FETCH.
- EXE_R:
  - ALUOp from Funct: add/addu->ADD, sub/subu->SUB, and, or, xor, nor, slt, sltu, sllv, srlv, srav map to their ALU_* codes.
  - sll/srl/sra use ALUSrcA=10 (shamt in A[10:6]); all others use ALUSrcA=01. ALUSrcB=00.
  - Unknown funct -> FETCH with illegal=1.
  - Next ALUWB.
- EXE_I:
  - ALUSrcA=01, ALUSrcB=10.
  - EXTOp=1 for addi/slti/sltiu; EXTOp=0 for andi/ori/xori/lui.
  - lui uses ALUOp=LUI.
  - Next ALUWB.
- ALUWB: RegWrite=1, WDSel=00; RegDst=01 for R-type, 00 for I-type; next FETCH.
- BRANCH:
  - ALUSrcA=01, ALUSrcB=00, PCSource=01.
  - beq: ALUOp=SUB, PCWrite=Zero.
  - bne: ALUOp=SUB, PCWrite=!Zero.
  - blez/bgtz/bltz/bgez: ALUOp=BLEZ/BGTZ/BLTZ/BGEZ, PCWrite=Zero (the ALU returns 0 when the condition holds).
  - Next FETCH.
- JUMP: PCSource=10, PCWrite=1. For jal also RegWrite=1, RegDst=10, WDSel=10 (PC already holds PC+4). Next FETCH.
- JR: PCSource=11, PCWrite=1; next FETCH.
- Latency in cycles, FETCH to next FETCH:
  - lw: 5
  - sw, R-type, I-type ALU: 4
  - branch, j, jal, jr: 3
- MemWrite, RegWrite and IRWrite are never asserted together in one cycle.
- The FSM never stalls; there is no memory wait handshake.

Test Plan:
- Hold rstn=0 for 3 cycles, release -> all outputs 0 during reset; RESET then FETCH with IRWrite=1, PCWrite=1, ALUOp=ADD.
- lw (Op=100011) -> state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; MEMWB has RegWrite=1, WDSel=01, RegDst=00; back in FETCH on cycle 6.
- R-type sra (Funct=000011) -> EXE_R with ALUSrcA=10 and ALUOp=ALU_SRA, then ALUWB with RegDst=01; 4 cycles total.
- beq with Zero=1 -> BRANCH PCWrite=1, PCSource=01. bne with Zero=1 -> PCWrite=0. bltz (Op=000001, Rt=0) -> ALUOp=ALU_BLTZ.
- jal (Op=000011) -> JUMP with PCWrite=1, RegWrite=1, RegDst=10, WDSel=10; FETCH next cycle.
- Op=111111 -> DECODE pulses illegal=1 for exactly one cycle, next state FETCH. Assert rstn=0 during MEMWR -> MemWrite drops immediately (async), state=RESET.
